// File: rtl/aes_wb_pkg.sv
// Shared definitions for the AES Wishbone initiator: register map offsets,
// sequencer states, control/status bit positions and a key/block word picker.
package aes_wb_pkg;

  localparam logic [31:0] OFS_KEY0   = 32'h00;
  localparam logic [31:0] OFS_TEXT0  = 32'h10;
  localparam logic [31:0] OFS_CTRL   = 32'h20;
  localparam logic [31:0] OFS_STATUS = 32'h24;
  localparam logic [31:0] OFS_RES0   = 32'h30;

  localparam int CTRL_START  = 0;
  localparam int STATUS_DONE = 0;

  // Fixed encoding so the state vector stays stable across tool versions
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_KEY  = 3'd1,
    S_WR_TEXT = 3'd2,
    S_START   = 3'd3,
    S_POLL    = 3'd4,
    S_RD_RES  = 3'd5,
    S_RESP    = 3'd6
  } state_e;

  // Word i of a 128-bit value, word 0 being the most significant
  function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] i);
    logic [31:0] w;
    w = v[127:96];
    case (i)
      2'd1:    w = v[95:64];
      2'd2:    w = v[63:32];
      2'd3:    w = v[31:0];
      default: w = v[127:96];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/aes_wb_if.sv
// Wishbone classic bus between the initiator (master) and the AES core (slave).
interface aes_wb_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );
  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/aes_wb_beat.sv
// Single-beat Wishbone classic engine. A beat starts on the first cycle req is
// seen with the bus idle; cyc/stb/adr/we/dat are registered and held until ack
// or until ACK_TIMEOUT strobe cycles pass. The bus is always idle for one
// cycle after a beat, so back-to-back requests cost two cycles per beat.
module aes_wb_beat #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic        timeout,
  output logic [31:0] rdata,
  aes_wb_if.master    wb
);

  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  logic        stb_q;
  logic        we_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic [7:0]  tmo_cnt;

  // ack only counts while strobing; timeout fires on the last allowed cycle
  assign done    = stb_q && wb.wbm_ack_i;
  assign timeout = stb_q && !wb.wbm_ack_i && (tmo_cnt == TMO_LAST);
  assign rdata   = wb.wbm_dat_i;

  assign wb.wbm_cyc_o = stb_q;
  assign wb.wbm_stb_o = stb_q;
  assign wb.wbm_we_o  = we_q;
  assign wb.wbm_sel_o = {4{stb_q}};
  assign wb.wbm_adr_o = adr_q;
  assign wb.wbm_dat_o = dat_q;

  // Launch a beat from idle, hold it until ack or timeout, then idle one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      tmo_cnt <= '0;
    end else if (stb_q) begin
      if (done || timeout) stb_q <= 1'b0;
      else                 tmo_cnt <= tmo_cnt + 8'd1;
    end else if (req) begin
      stb_q   <= 1'b1;
      we_q    <= we;
      adr_q   <= adr;
      dat_q   <= wdata;
      tmo_cnt <= '0;
    end
  end

endmodule

// File: rtl/aes_wb_initiator.sv
// Wishbone classic initiator for the AES core: takes key+block on a
// valid/ready command port, writes KEY/TEXT, starts the core, polls STATUS,
// reads RES and returns it on a valid/ready response port. Ack timeouts and
// poll exhaustion abort to the response with rsp_err=1 and zero data.
// Optional: AES_WB_INITIATOR_KEY_CACHE_EN skips the key writes when the new
// key matches the last one loaded successfully.
module aes_wb_initiator
  import aes_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned POLL_LIMIT  = 1023
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [127:0] cmd_key,
  input  logic [127:0] cmd_block,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  aes_wb_if.master     wbm
);

  localparam logic [9:0] POLL_LAST = 10'(POLL_LIMIT - 1);

  state_e       state;
  logic [1:0]   wc;
  logic [9:0]   poll_cnt;
  logic [127:0] key_q;
  logic [127:0] blk_q;
  logic [127:0] res_q;
  logic         err_q;

  logic         beat_req, beat_we, beat_done, beat_tmo;
  logic [31:0]  beat_adr, beat_wdata, beat_rdata;
  logic         poll_abort, abort, cache_hit;

  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_data  = res_q;
  assign rsp_err   = err_q;

  assign poll_abort = (state == S_POLL) && beat_done &&
                      !beat_rdata[STATUS_DONE] && (poll_cnt == POLL_LAST);
  assign abort      = beat_tmo || poll_abort;

  // Bus request for the current step; the word counter walks the 4-word groups
  always_comb begin
    beat_req   = 1'b0;
    beat_we    = 1'b0;
    beat_adr   = BASE_ADDR;
    beat_wdata = '0;
    case (state)
      S_WR_KEY: begin
        beat_req   = 1'b1;
        beat_we    = 1'b1;
        beat_adr   = BASE_ADDR + OFS_KEY0 + 32'({wc, 2'b00});
        beat_wdata = word_of(key_q, wc);
      end
      S_WR_TEXT: begin
        beat_req   = 1'b1;
        beat_we    = 1'b1;
        beat_adr   = BASE_ADDR + OFS_TEXT0 + 32'({wc, 2'b00});
        beat_wdata = word_of(blk_q, wc);
      end
      S_START: begin
        beat_req   = 1'b1;
        beat_we    = 1'b1;
        beat_adr   = BASE_ADDR + OFS_CTRL;
        beat_wdata = 32'd1 << CTRL_START;
      end
      S_POLL: begin
        beat_req = 1'b1;
        beat_adr = BASE_ADDR + OFS_STATUS;
      end
      S_RD_RES: begin
        beat_req = 1'b1;
        beat_adr = BASE_ADDR + OFS_RES0 + 32'({wc, 2'b00});
      end
      default: ;
    endcase
  end

  aes_wb_beat #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_beat (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .req     (beat_req),
    .we      (beat_we),
    .adr     (beat_adr),
    .wdata   (beat_wdata),
    .done    (beat_done),
    .timeout (beat_tmo),
    .rdata   (beat_rdata),
    .wb      (wbm)
  );

`ifdef AES_WB_INITIATOR_KEY_CACHE_EN
  logic [127:0] kc_key;
  logic         kc_vld;

  assign cache_hit = kc_vld && (cmd_key == kc_key);

  // Remember a key once all four KEY words are acked; any abort forgets it
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      kc_vld <= 1'b0;
      kc_key <= '0;
    end else if (abort) begin
      kc_vld <= 1'b0;
    end else if (state == S_WR_KEY && beat_done && wc == 2'd3) begin
      kc_vld <= 1'b1;
      kc_key <= key_q;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // Sequencer: KEY -> TEXT -> CTRL -> poll STATUS -> RES -> response
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= S_IDLE;
      wc       <= '0;
      poll_cnt <= '0;
      key_q    <= '0;
      blk_q    <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else if (abort) begin
      state <= S_RESP;
      res_q <= '0;
      err_q <= 1'b1;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          key_q <= cmd_key;
          blk_q <= cmd_block;
          res_q <= '0;
          err_q <= 1'b0;
          wc    <= '0;
          state <= cache_hit ? S_WR_TEXT : S_WR_KEY;
        end
        S_WR_KEY: if (beat_done) begin
          wc <= wc + 2'd1;
          if (wc == 2'd3) state <= S_WR_TEXT;
        end
        S_WR_TEXT: if (beat_done) begin
          wc <= wc + 2'd1;
          if (wc == 2'd3) state <= S_START;
        end
        S_START: if (beat_done) begin
          poll_cnt <= '0;
          state    <= S_POLL;
        end
        S_POLL: if (beat_done) begin
          if (beat_rdata[STATUS_DONE]) begin
            wc    <= '0;
            state <= S_RD_RES;
          end else begin
            poll_cnt <= poll_cnt + 10'd1;
          end
        end
        S_RD_RES: if (beat_done) begin
          res_q <= {res_q[95:0], beat_rdata};
          wc    <= wc + 2'd1;
          if (wc == 2'd3) state <= S_RESP;
        end
        S_RESP: if (rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_wb_initiator.sv
// Directed bench for aes_wb_initiator with a behavioural AES-core responder:
// acks in the first strobe cycle, reports done on a chosen STATUS read and
// returns a chosen ciphertext from RES0..3. Also covers ack timeout, poll
// exhaustion, response backpressure, mid-transfer reset and (when
// AES_WB_INITIATOR_KEY_CACHE_EN is defined) key-cache skipping.
module tb_aes_wb_initiator;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [127:0] cmd_key = '0;
  logic [127:0] cmd_block = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_data;
  logic         rsp_err;

  aes_wb_if bus();

  aes_wb_initiator dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_key   (cmd_key),
    .cmd_block (cmd_block),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .wbm       (bus)
  );

  always #5 clk = ~clk;

  // ---------------- responder model ----------------
  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } bus_t;

  bus_t         log_q[$];
  bus_t         exp_q[$];
  int           status_cnt = 0;
  int           nak_cnt = 0;
  int           stat_base = 0;
  int           done_on = 1;
  logic [127:0] cur_ct = '0;
  logic         nak_en = 1'b0;
  logic [31:0]  nak_adr = '0;

  function automatic logic [31:0] wsel(input logic [127:0] v, input int i);
    return v[127-32*i -: 32];
  endfunction

  always_comb begin
    bus.wbm_ack_i = bus.wbm_stb_o && !(nak_en && bus.wbm_adr_o == nak_adr);
    bus.wbm_dat_i = 32'h0;
    if (bus.wbm_adr_o == BASE + 32'h24)
      bus.wbm_dat_i = {31'b0, (done_on != 0) && (status_cnt - stat_base + 1 >= done_on)};
    else if (bus.wbm_adr_o[31:4] == BASE[31:4] + 28'h3)
      bus.wbm_dat_i = wsel(cur_ct, int'(bus.wbm_adr_o[3:2]));
  end

  always @(posedge clk) begin
    if (bus.wbm_stb_o && bus.wbm_ack_i) begin
      log_q.push_back({bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o,
                       bus.wbm_we_o ? bus.wbm_dat_o : bus.wbm_dat_i});
      if (!bus.wbm_we_o && bus.wbm_adr_o == BASE + 32'h24) status_cnt <= status_cnt + 1;
    end
    if (bus.wbm_stb_o && nak_en && bus.wbm_adr_o == nak_adr) nak_cnt <= nak_cnt + 1;
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Present one command, wait (bounded) for rsp_valid; lat counts cycles
  // from the handshake edge to the first cycle rsp_valid is seen
  task automatic issue(input logic [127:0] k, input logic [127:0] b,
                       input logic [127:0] c, input int dn, output int lat);
    cur_ct    = c;
    done_on   = dn;
    stat_base = status_cnt;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_key   = k;
    cmd_block = b;
    lat = 0;
    do begin
      @(negedge clk);
      cmd_valid = 1'b0;
      lat++;
    end while (!rsp_valid && lat < 5000);
    chk("rsp_valid_seen", 128'(rsp_valid), 128'(1));
  endtask

  task automatic accept();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // Bus order the register map implies for one full command
  task automatic build_exp(input logic [127:0] k, input logic [127:0] b,
                           input logic [127:0] c, input int dn);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 4'hF, BASE + 32'(4*i), wsel(k, i)});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 4'hF, BASE + 32'h10 + 32'(4*i), wsel(b, i)});
    exp_q.push_back({1'b1, 4'hF, BASE + 32'h20, 32'h1});
    for (int p = 1; p <= dn; p++) exp_q.push_back({1'b0, 4'hF, BASE + 32'h24, (p == dn) ? 32'h1 : 32'h0});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 4'hF, BASE + 32'h30 + 32'(4*i), wsel(c, i)});
  endtask

  function automatic int key_writes(input int from);
    int n = 0;
    for (int j = from; j < log_q.size(); j++)
      if (log_q[j].we && log_q[j].adr < BASE + 32'h10) n++;
    return n;
  endfunction

  typedef struct {
    logic [127:0] key;
    logic [127:0] blk;
    logic [127:0] ct;       // what the responder hands back from RES0..3
    int           done_on;  // STATUS read that first reports done
    logic         exp_err;
    logic [127:0] exp_data;
    int           exp_lat;  // 2 cycles per beat, 13 fixed beats + polls, +1
  } vec_t;

`ifdef AES_WB_INITIATOR_KEY_CACHE_EN
  localparam int EXP_KW_SAME = 0;
`else
  localparam int EXP_KW_SAME = 4;
`endif

  initial begin
    vec_t         vt[3];
    int           lat, base, bad;
    logic [127:0] d0;
    logic         ok, found;

    vt[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 3, 1'b0,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 33};
    vt[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
              128'h3925841d02dc09fbdc118597196a0b32, 1, 1'b0,
              128'h3925841d02dc09fbdc118597196a0b32, 29};
    vt[2] = '{{128{1'b1}}, 128'h0,
              128'h0123456789abcdeffedcba9876543210, 2, 1'b0,
              128'h0123456789abcdeffedcba9876543210, 31};

    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_data}, '0);
    chk("rst_bus", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o,
                    bus.wbm_adr_o, bus.wbm_dat_o}, '0);

    // table-driven full commands
    for (int v = 0; v < 3; v++) begin
      base = log_q.size();
      build_exp(vt[v].key, vt[v].blk, vt[v].ct, vt[v].done_on);
      issue(vt[v].key, vt[v].blk, vt[v].ct, vt[v].done_on, lat);
      chk($sformatf("v%0d_data", v), rsp_data, vt[v].exp_data);
      chk($sformatf("v%0d_err", v), 128'(rsp_err), 128'(vt[v].exp_err));
      chk($sformatf("v%0d_latency", v), 128'(lat), 128'(vt[v].exp_lat));
      chk($sformatf("v%0d_bus_len", v), 128'(log_q.size() - base), 128'(exp_q.size()));
      bad = -1;
      for (int j = 0; j < exp_q.size() && base + j < log_q.size(); j++)
        if (bad < 0 && log_q[base + j] !== exp_q[j]) bad = j;
      checks++;
      if (bad >= 0) begin
        failures++;
        $display("FAIL v%0d_bus_seq beat %0d actual=%h required=%h", v, bad,
                 log_q[base + bad], exp_q[bad]);
      end
      accept();
    end

    // backpressure: response held, no bus activity, then IDLE next cycle
    issue(128'h11, 128'h22, 128'hcafe_f00d, 1, lat);
    d0 = rsp_data;
    base = log_q.size();
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (rsp_data !== d0 || !rsp_valid || cmd_ready || bus.wbm_cyc_o || bus.wbm_stb_o) ok = 1'b0;
    end
    chk("hold_stable", 128'(ok), 128'(1));
    chk("hold_no_beats", 128'(log_q.size() - base), 128'(0));
    chk("hold_data", d0, 128'hcafe_f00d);
    accept();
    chk("release_idle", {cmd_ready, rsp_valid}, 128'b10);

    // KEY2 never acked: 255 strobe cycles then abort
    nak_en  = 1'b1;
    nak_adr = BASE + 32'h08;
    base = nak_cnt;
    bad  = log_q.size();
    issue(128'h33, 128'h44, 128'h55, 1, lat);
    chk("tmo_stb_cycles", 128'(nak_cnt - base), 128'(255));
    chk("tmo_beats_before", 128'(log_q.size() - bad), 128'(2));
    chk("tmo_err", 128'(rsp_err), 128'(1));
    chk("tmo_data", rsp_data, '0);
    chk("tmo_cyc", {bus.wbm_cyc_o, bus.wbm_stb_o}, '0);
    nak_en = 1'b0;
    accept();

    // STATUS never done: exactly POLL_LIMIT reads then abort
    issue(128'h66, 128'h77, 128'h88, 0, lat);
    chk("poll_reads", 128'(status_cnt - stat_base), 128'(1023));
    chk("poll_err", 128'(rsp_err), 128'(1));
    chk("poll_data", rsp_data, '0);
    accept();

    // reset while the second RES read is on the bus
    cur_ct  = 128'h99;
    done_on = 1;
    stat_base = status_cnt;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_key   = 128'haa;
    cmd_block = 128'hbb;
    @(negedge clk);
    cmd_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (bus.wbm_stb_o && bus.wbm_adr_o == BASE + 32'h34) found = 1'b1;
      else @(negedge clk);
    end
    chk("rstmid_reached", 128'(found), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_bus", {bus.wbm_cyc_o, bus.wbm_stb_o}, '0);
    chk("rstmid_ready", {cmd_ready, rsp_valid}, 128'b10);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rstmid_quiet", {rsp_valid, bus.wbm_cyc_o}, '0);

    // key reuse: same key twice, then a new key
    base = log_q.size();
    issue(128'hdead_beef, 128'h1, 128'h2, 1, lat);
    accept();
    chk("kc_first_writes", 128'(key_writes(base)), 128'(4));
    base = log_q.size();
    issue(128'hdead_beef, 128'h3, 128'h4, 1, lat);
    chk("kc_same_data", rsp_data, 128'h4);
    accept();
    chk("kc_same_writes", 128'(key_writes(base)), 128'(EXP_KW_SAME));
    base = log_q.size();
    issue(128'hfeed_face, 128'h5, 128'h6, 1, lat);
    accept();
    chk("kc_new_writes", 128'(key_writes(base)), 128'(4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

endmodule
